instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the single-issue core, sitting directly downstream of the PC register. Each cycle it reads the current PC, issues a word read to instruction memory over a req/ack handshake, and latches the returned instruction into an instruction register for decode. It drives the PC register's write enable and next-address input, advancing by 4 on each completed fetch or loading a redirect target. It also detects misaligned-PC and memory-timeout faults.

## Interface
- TIMEOUT, 16: consecutive req-without-ack cycles before a timeout fault (≥2).
- NOP, 32'h00000013: reset and squash value of the instruction register.

- IF_clk  in  1  rising-edge clock.
- IF_rst_n  in  1  asynchronous, active-low reset.
- IF_pc  in  32  current PC (PC register count output).
- IF_pc_write  out  1  PC register write enable.
- IF_pc_next  out  32  PC register data in.
- IF_redirect  in  1  branch/jump/trap redirect, single-cycle.
- IF_redirect_addr  in  32  redirect target.
- IF_mem_req  out  1  instruction memory read request.
- IF_mem_addr  out  32  read address.
- IF_mem_ack  in  1  read complete; IF_mem_rdata valid this cycle.
- IF_mem_rdata  in  32  read data.
- IF_ir  out  32  instruction register.
- IF_ir_pc  out  32  PC of IF_ir.
- IF_ir_valid  out  1  IF_ir holds an instruction for decode.
- IF_ir_ready  in  1  decode accepts IF_ir this cycle.
- IF_fault  out  1  fault pending.
- IF_fault_code  out  2  01 misaligned, 10 timeout, 00 none.

## Operation
- States: IDLE, FETCH, VALID, DRAIN, FAULT. Reset state IDLE.
- Registered outputs reset: IF_ir=NOP, IF_ir_pc=0, IF_ir_valid=0, IF_fault=0, IF_fault_code=00, wait counter=0. Combinational outputs in reset/IDLE: IF_mem_req=0, IF_pc_write=0, IF_pc_next=IF_pc+4.
- IDLE: one cycle, lets the synchronous-reset PC register settle; → FETCH.
- FETCH: if IF_pc[1:0]≠0: no request, IF_fault=1, code 01, → FAULT. Otherwise IF_mem_req=1, IF_mem_addr=IF_pc (stable; PC written only on ack/redirect). On IF_mem_ack: IF_ir←IF_mem_rdata, IF_ir_pc←IF_pc, IF_ir_valid←1, IF_pc_write=1, IF_pc_next=IF_pc+4 (mod 2^32, 0xFFFFFFFC→0), → VALID.
- VALID: IF_ir_valid=1, IF_ir/IF_ir_pc stable. On IF_ir_ready: IF_ir_valid←0, → FETCH.
- Handshake: once asserted, IF_mem_req stays high with constant IF_mem_addr until IF_mem_ack (except entry to FAULT on timeout). Ack while req low is ignored.
- Redirect (highest priority, any state): IF_pc_write=1, IF_pc_next=IF_redirect_addr; IF_ir_valid←0, IF_ir←NOP.
  - IDLE/VALID/FAULT: → FETCH; FAULT also clears IF_fault and code. IF_ir_ready in the same cycle is ignored (squashed).
  - FETCH with ack same cycle: data discarded, → FETCH.
  - FETCH without ack: latch drain address ← IF_pc, → DRAIN.
  - DRAIN: redirect reloads PC, stays DRAIN.
- DRAIN: IF_mem_req=1, IF_mem_addr=drain address; on ack discard data, → FETCH.
- Timeout: counter increments each FETCH/DRAIN cycle with req and no ack, clears on ack or state exit. On the TIMEOUT-th such cycle: IF_mem_req drops, IF_fault=1, code 10, → FAULT.
- FAULT: req=0, ir_valid=0; held until redirect or reset.
- Async reset mid-transaction: all state/outputs return to reset values immediately; outstanding memory response ignored.

## Timing
- Zero-wait memory: FETCH entry (cycle n), ack in n → IF_ir_valid high n+1; PC updated at edge ending n.
- W wait states: IF_ir_valid at n+W+1.
- Throughput: one instruction per 2 cycles minimum (FETCH, VALID).
- Redirect → first request to new address: next cycle (FETCH), or after drain ack.
- Fault flags registered; visible cycle after detection.
- First request: second cycle after IF_rst_n deasserts.

## Test plan
- Reset with IF_pc=0, zero-wait memory returning 0x00500093: req at addr 0 in cycle 2; IF_ir=0x00500093, IF_ir_pc=0, valid next cycle; IF_pc_next=4 with IF_pc_write pulse.
- 3 wait states, IF_ir_ready held low 4 cycles: req/addr stable through waits; IF_ir stable while valid; next fetch only after ready.
- Redirect to 0x100 during wait on addr 0x20: DRAIN holds addr 0x20 until ack, data discarded, next req at 0x100, IF_ir_valid never set for 0x20.
- No ack for TIMEOUT=16 cycles: req drops on cycle 16, IF_fault=1, code 10; redirect to 0x200 clears fault and fetches 0x200.
- IF_pc=0x102: no req, IF_fault=1, code 01.
- IF_pc=0xFFFFFFFC fetch ack: IF_pc_next=0; async reset asserted mid-wait: req=0, IF_ir=NOP immediately.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC-driven word read, IR latch, redirect drain, fault detect
module instr_fetch #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic        IF_clk,
  input  logic        IF_rst_n,
  input  logic [31:0] IF_pc,
  output logic        IF_pc_write,
  output logic [31:0] IF_pc_next,
  input  logic        IF_redirect,
  input  logic [31:0] IF_redirect_addr,
  output logic        IF_mem_req,
  output logic [31:0] IF_mem_addr,
  input  logic        IF_mem_ack,
  input  logic [31:0] IF_mem_rdata,
  output logic [31:0] IF_ir,
  output logic [31:0] IF_ir_pc,
  output logic        IF_ir_valid,
  input  logic        IF_ir_ready,
  output logic        IF_fault,
  output logic [1:0]  IF_fault_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic [31:0]   drain_addr;
  logic          misaligned;
  logic          ack_take;
  logic          timeout_hit;

  assign misaligned  = (IF_pc[1:0] != 2'b00);
  assign ack_take    = IF_mem_req & IF_mem_ack;
  assign timeout_hit = IF_mem_req & ~IF_mem_ack & (wait_cnt >= CNT_LAST);

  always_comb begin
    IF_mem_req  = 1'b0;
    IF_mem_addr = IF_pc;
    case (state)
      S_FETCH: IF_mem_req = ~misaligned;
      S_DRAIN: begin
        IF_mem_req  = 1'b1;
        IF_mem_addr = drain_addr;
      end
      default: IF_mem_req = 1'b0;
    endcase
  end

  always_comb begin
    IF_pc_write = 1'b0;
    IF_pc_next  = IF_pc + 32'd4;
    if (IF_redirect) begin
      IF_pc_write = 1'b1;
      IF_pc_next  = IF_redirect_addr;
    end else if (state == S_FETCH && ack_take) begin
      IF_pc_write = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        // A redirect while a read is outstanding must still swallow its response
        if (IF_redirect)      state_nxt = (IF_mem_req & ~IF_mem_ack) ? S_DRAIN : S_FETCH;
        else if (misaligned)  state_nxt = S_FAULT;
        else if (ack_take)    state_nxt = S_VALID;
        else if (timeout_hit) state_nxt = S_FAULT;
      end
      S_VALID: if (IF_redirect || IF_ir_ready) state_nxt = S_FETCH;
      S_DRAIN: begin
        if (ack_take)                        state_nxt = S_FETCH;
        else if (timeout_hit && !IF_redirect) state_nxt = S_FAULT;
      end
      S_FAULT: if (IF_redirect) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Saturates one short of TIMEOUT so a redirect-held drain still faults later
  always_comb begin
    wait_cnt_nxt = '0;
    if (IF_mem_req && !IF_mem_ack && state_nxt == state)
      wait_cnt_nxt = (wait_cnt >= CNT_LAST) ? wait_cnt : wait_cnt + CW'(1);
  end

  always_ff @(posedge IF_clk or negedge IF_rst_n) begin
    if (!IF_rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      drain_addr    <= '0;
      IF_ir         <= NOP;
      IF_ir_pc      <= '0;
      IF_ir_valid   <= 1'b0;
      IF_fault      <= 1'b0;
      IF_fault_code <= 2'b00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_FETCH && state_nxt == S_DRAIN)
        drain_addr <= IF_pc;
      if (IF_redirect) begin
        IF_ir         <= NOP;
        IF_ir_valid   <= 1'b0;
        IF_fault      <= 1'b0;
        IF_fault_code <= 2'b00;
      end else begin
        case (state)
          S_FETCH: begin
            if (misaligned) begin
              IF_fault      <= 1'b1;
              IF_fault_code <= 2'b01;
            end else if (ack_take) begin
              IF_ir       <= IF_mem_rdata;
              IF_ir_pc    <= IF_pc;
              IF_ir_valid <= 1'b1;
            end else if (timeout_hit) begin
              IF_fault      <= 1'b1;
              IF_fault_code <= 2'b10;
            end
          end
          S_VALID: if (IF_ir_ready) IF_ir_valid <= 1'b0;
          S_DRAIN: begin
            if (!ack_take && timeout_hit) begin
              IF_fault      <= 1'b1;
              IF_fault_code <= 2'b10;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
